serial_word_receiver: RTL and testbench
=======================================

# serial_word_receiver

Serial-in/parallel-out receiver for the 14-bit word link driven by the team's parallel-load, MSB-first left-shift transmitter. It qualifies incoming bits, assembles N-bit words MSB first, and presents each completed word on a registered valid/ready output. The output stage is double-buffered so that the next frame can be received while a word waits. It sits at the receive end of the serial word path, feeding the downstream word consumer.

## Interface
- `N`, default 14: word width in bits; minimum 2.
- `clk`, in, 1: sole clock; all logic is rising-edge.
- `rst`, in, 1: synchronous, active-high reset.
- `shift_en`, in, 1: bit qualifier; `serial_in` is sampled only on edges where this is high.
- `frame_start`, in, 1: marks the qualified bit as bit N-1 (MSB) of a new frame; ignored when `shift_en` is low.
- `serial_in`, in, 1: serial data, MSB first.
- `data_out`, out, N: last delivered word; registered.
- `data_valid`, out, 1: `data_out` holds an unconsumed word.
- `data_ready`, in, 1: consumer accepts `data_out` on an edge where `data_valid` and `data_ready` are both high.
- `busy`, out, 1: a frame is in progress.
- `overrun`, out, 1: sticky; a completed word was dropped. Cleared only by `rst`.
- `parity_err`, out, 1: present only with `RX_PARITY_EN`; qualifies `data_out`.

## Operation
- FSM states: IDLE, SHIFT (plus PARITY when `RX_PARITY_EN` is defined). Shift register `sr[N-1:0]` and bit counter `cnt` (0..N).
- IDLE: a qualified bit with `frame_start` high gives `sr <= {.., serial_in}`, `cnt <= 1`, next state SHIFT. A qualified bit without `frame_start` is ignored.
- SHIFT: each qualified bit gives `sr <= {sr[N-2:0], serial_in}` and increments `cnt`.
- On the qualified bit that makes `cnt == N`, the word `{sr[N-2:0], serial_in}` completes and the FSM returns to IDLE (or enters PARITY).
- Completion with the output slot free (`!data_valid`, or `data_valid && data_ready` on the same edge): `data_out <=` word, `data_valid <= 1`.
- Completion with the slot occupied and not being consumed: the word is dropped, `data_out` is held, `overrun <= 1`.
- Consumption without completion: `data_valid <= 0`; `data_out` holds its value.
- `frame_start` on a qualified bit in SHIFT (or PARITY) aborts the partial frame, then restarts with that bit as the MSB (`cnt <= 1`). No flag is raised.
- `busy` is high in SHIFT and PARITY.
- `cnt` width is `$clog2(N+1)`; `cnt` never exceeds N.

## Timing
- Reset values: `data_out = 0`, `data_valid = 0`, `busy = 0`, `overrun = 0`, `parity_err = 0`. State is IDLE and `cnt = 0`.
- `rst` mid-frame discards the partial word; a pending `data_out` is also cleared.
- Latency: `data_valid` is high in the cycle after the edge that samples the last bit (the last data bit, or the parity bit).
- Minimum frame: N consecutive qualified cycles. Back-to-back frames at full rate with `data_ready` tied high produce no overrun.
- `data_valid` may drop only after a consumption edge. `data_out` is stable while `data_valid` is high.

## Configuration
- `RX_PARITY_EN` defined:
  - After bit N the FSM enters PARITY and accepts one more qualified bit as the parity bit.
  - Even parity: the XOR of the data bits and the parity bit must be 0.
  - The word and `parity_err` are delivered together on the parity-bit edge.
  - `frame_start` in PARITY restarts the frame.
- `RX_PARITY_EN` undefined:
  - No PARITY state and no `parity_err` port.
  - Delivery occurs on bit N.

## Structure
- Shared package `serial_link_pkg` holds:
  - the state enum `rx_state_t` (IDLE, SHIFT, PARITY);
  - `SERIAL_WORD_W = 14`;
  - a parity helper function, shared with the transmitter.
- One sub-module, `rx_bit_counter`: a parameterized counter with load-to-1, increment and terminal-count (`cnt == N`) outputs.

## Test plan
- Shift 14'h2A5C MSB first with `frame_start` on the first bit and `data_ready = 1` → one cycle after bit 14, `data_out = 14'h2A5C` and `data_valid = 1`; the pulse lasts one cycle.
- Send two frames back-to-back, 14'h3FFF then 14'h0001, with `data_ready = 0` → `data_out` holds 14'h3FFF and `overrun = 1`; raising `data_ready` then clears `data_valid`.
- Send 6 bits of one frame, then assert `frame_start` with a new frame 14'h1234 → `data_out = 14'h1234`; the partial frame is never delivered.
- Toggle `shift_en` randomly (50%) while sending 14'h0AAA → `data_out = 14'h0AAA`; unqualified cycles have no effect.
- Assert `rst` after 9 bits, then send a full frame 14'h2222 → outputs are 0 immediately after the reset edge, then `data_out = 14'h2222`.
- With `RX_PARITY_EN`, send 14'h0003 with parity bit 1 → `parity_err = 1`. Send 14'h0003 with parity bit 0 → `parity_err = 0`.

Source files
------------

// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial word link: receiver states, word width, parity helper.
package serial_link_pkg;

  localparam int unsigned SERIAL_WORD_W = 14;
  localparam int unsigned PARITY_MAX_W  = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } rx_state_t;

  // Returns 1 when the vector has an odd number of ones (even-parity violation).
  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] bits_in);
    return ^bits_in;
  endfunction

endpackage

// File: rtl/serial_word_receiver_if.sv
// Receiver-side bundle: serial input qualifiers plus the word valid/ready output.
// parity_err exists only when RX_PARITY_EN is defined.
interface serial_word_receiver_if
  import serial_link_pkg::*;
#(
  parameter int unsigned N = SERIAL_WORD_W
);
  logic         shift_en;
  logic         frame_start;
  logic         serial_in;
  logic [N-1:0] data_out;
  logic         data_valid;
  logic         data_ready;
  logic         busy;
  logic         overrun;
`ifdef RX_PARITY_EN
  logic         parity_err;
`endif

  // Receiver side: consumes the serial stream, produces words.
  modport master (
`ifdef RX_PARITY_EN
    output parity_err,
`endif
    input  shift_en,
    input  frame_start,
    input  serial_in,
    input  data_ready,
    output data_out,
    output data_valid,
    output busy,
    output overrun
  );

  // Environment side: drives the serial stream, consumes words.
  modport slave (
`ifdef RX_PARITY_EN
    input  parity_err,
`endif
    output shift_en,
    output frame_start,
    output serial_in,
    output data_ready,
    input  data_out,
    input  data_valid,
    input  busy,
    input  overrun
  );

endinterface

// File: rtl/rx_bit_counter.sv
// Frame bit counter 0..N: load-to-1, clear, saturating increment, last/terminal flags.
module rx_bit_counter #(
  parameter int unsigned N = 14
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic load,
  input  logic inc,
  output logic last_c,
  output logic tc_c
);

  localparam int unsigned CW = $clog2(N + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign last_c = (cnt_q == CW'(N - 1));
  assign tc_c   = (cnt_q == CW'(N));

  // Load wins so a restart on the same edge as an idle tidy-up is honoured.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CW'(1);
    end else if (clr) begin
      cnt_d = '0;
    end else if (inc && !tc_c) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_word_receiver.sv
// MSB-first serial-to-parallel word receiver with a registered valid/ready output slot.
// Optional even-parity bit after each word when RX_PARITY_EN is defined.
module serial_word_receiver
  import serial_link_pkg::*;
#(
  parameter int unsigned N = SERIAL_WORD_W
) (
  input  logic                   clk,
  input  logic                   rst,
  serial_word_receiver_if.master rx_if
);

  // Without parity the final bit bypasses the shifter, so only N-1 bits are stored.
`ifdef RX_PARITY_EN
  localparam int unsigned SR_W = N;
`else
  localparam int unsigned SR_W = N - 1;
`endif

  rx_state_t       state_q, state_d;
  logic [SR_W-1:0] sr_q, sr_d;
  logic [N-1:0]    data_q, data_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic            overrun_q, overrun_d;
  logic [N-1:0]    word_c;
  logic            complete_c;
  logic            consume_c;
  logic            cnt_clr, cnt_load, cnt_inc;
  logic            cnt_last_c, cnt_tc_c;
`ifdef RX_PARITY_EN
  logic            perr_q, perr_d;
  logic            word_perr_c;
`endif

  rx_bit_counter #(.N(N)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .load   (cnt_load),
    .inc    (cnt_inc),
    .last_c (cnt_last_c),
    .tc_c   (cnt_tc_c)
  );

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    data_d     = data_q;
    valid_d    = valid_q;
    overrun_d  = overrun_q;
    complete_c = 1'b0;
    cnt_clr    = 1'b0;
    cnt_load   = 1'b0;
    cnt_inc    = 1'b0;
    consume_c  = valid_q && rx_if.data_ready;
`ifdef RX_PARITY_EN
    perr_d      = perr_q;
    word_c      = sr_q;
    word_perr_c = even_parity(PARITY_MAX_W'({sr_q, rx_if.serial_in}));
`else
    word_c      = {sr_q, rx_if.serial_in};
`endif

    // Return the counter to zero once a finished frame has left SHIFT.
    if (state_q == IDLE && cnt_tc_c) begin
      cnt_clr = 1'b1;
    end

    if (rx_if.shift_en) begin
      if (rx_if.frame_start) begin
        sr_d     = SR_W'(rx_if.serial_in);
        cnt_load = 1'b1;
        state_d  = SHIFT;
      end else begin
        case (state_q)
          SHIFT: begin
            sr_d    = SR_W'({sr_q, rx_if.serial_in});
            cnt_inc = 1'b1;
            if (cnt_last_c) begin
`ifdef RX_PARITY_EN
              state_d    = PARITY;
`else
              state_d    = IDLE;
              complete_c = 1'b1;
`endif
            end
          end
`ifdef RX_PARITY_EN
          PARITY: begin
            state_d    = IDLE;
            complete_c = 1'b1;
          end
`endif
          default: ;
        endcase
      end
    end

    if (consume_c) begin
      valid_d = 1'b0;
    end

    // A word lands only in a free (or simultaneously drained) slot; otherwise it is lost.
    if (complete_c) begin
      if (!valid_q || consume_c) begin
        data_d  = word_c;
        valid_d = 1'b1;
`ifdef RX_PARITY_EN
        perr_d  = word_perr_c;
`endif
      end else begin
        overrun_d = 1'b1;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
`ifdef RX_PARITY_EN
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
`ifdef RX_PARITY_EN
      perr_q    <= perr_d;
`endif
    end
  end

  assign rx_if.data_out   = data_q;
  assign rx_if.data_valid = valid_q;
  assign rx_if.busy       = busy_q;
  assign rx_if.overrun    = overrun_q;
`ifdef RX_PARITY_EN
  assign rx_if.parity_err = perr_q;
`endif

endmodule

// File: tb/tb_serial_word_receiver.sv
// Bench for serial_word_receiver: directed scenarios plus random traffic against a
// bit-accumulating reference model; honours RX_PARITY_EN.
module tb_serial_word_receiver;
  import serial_link_pkg::*;

  localparam int unsigned N = SERIAL_WORD_W;

  logic clk = 1'b0;
  logic rst = 1'b0;

  serial_word_receiver_if #(.N(N)) rx_if ();

  serial_word_receiver #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .rx_if (rx_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: m_bits counts bits received in the current frame (0 = none),
  // m_acc accumulates them arithmetically, m_* mirror the output slot.
  int           m_bits;
  int           m_acc;
  logic [N-1:0] m_data;
  logic         m_valid;
  logic         m_overrun;
  logic         m_perr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_bits    = 0;
    m_acc     = 0;
    m_data    = '0;
    m_valid   = 1'b0;
    m_overrun = 1'b0;
    m_perr    = 1'b0;
  endfunction

  function automatic void model_edge(input logic en, input logic fs, input logic sin,
                                     input logic rdy);
    logic         done;
    logic [N-1:0] w;
    logic         pe;
    done = 1'b0;
    w    = '0;
    pe   = 1'b0;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_valid && rdy) m_valid = 1'b0;
    if (en) begin
      if (fs) begin
        m_acc  = int'(sin);
        m_bits = 1;
      end else if (m_bits > 0 && m_bits < int'(N)) begin
        m_acc  = m_acc * 2 + int'(sin);
        m_bits = m_bits + 1;
`ifndef RX_PARITY_EN
        if (m_bits == int'(N)) begin
          done   = 1'b1;
          w      = N'(m_acc);
          m_bits = 0;
        end
`endif
      end
`ifdef RX_PARITY_EN
      else if (m_bits == int'(N)) begin
        done   = 1'b1;
        w      = N'(m_acc);
        pe     = ((($countones(w) + int'(sin)) % 2) == 1);
        m_bits = 0;
      end
`endif
    end
    if (done) begin
      if (!m_valid) begin
        m_data  = w;
        m_valid = 1'b1;
        m_perr  = pe;
      end else begin
        m_overrun = 1'b1;
      end
    end
  endfunction

  task automatic compare_all();
    chk("data_out", 32'(rx_if.data_out), 32'(m_data));
    chk("data_valid", 32'(rx_if.data_valid), 32'(m_valid));
    chk("busy", 32'(rx_if.busy), 32'(m_bits > 0));
    chk("overrun", 32'(rx_if.overrun), 32'(m_overrun));
`ifdef RX_PARITY_EN
    chk("parity_err", 32'(rx_if.parity_err), 32'(m_perr));
`endif
  endtask

  // One clock: drive inputs, advance the model on the edge, compare 1 time unit later.
  task automatic step(input logic en, input logic fs, input logic sin, input logic rdy);
    rx_if.shift_en    = en;
    rx_if.frame_start = fs;
    rx_if.serial_in   = sin;
    rx_if.data_ready  = rdy;
    @(posedge clk);
    model_edge(en, fs, sin, rdy);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic send_bit(input logic b, input logic fs, input int en_pct, input logic rdy);
    while (int'($urandom_range(99)) >= en_pct)
      step(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), rdy);
    step(1'b1, fs, b, rdy);
  endtask

  // Sends a frame; with parity enabled a correct even-parity bit follows.
  task automatic send_frame(input logic [N-1:0] w, input int en_pct, input logic rdy);
    for (int i = int'(N) - 1; i >= 0; i--) send_bit(w[i], i == int'(N) - 1, en_pct, rdy);
`ifdef RX_PARITY_EN
    send_bit(^w, 1'b0, en_pct, rdy);
`endif
  endtask

`ifdef RX_PARITY_EN
  task automatic send_frame_par(input logic [N-1:0] w, input logic par);
    for (int i = int'(N) - 1; i >= 0; i--) send_bit(w[i], i == int'(N) - 1, 100, 1'b1);
    send_bit(par, 1'b0, 100, 1'b1);
  endtask
`endif

  initial begin
    rx_if.shift_en    = 1'b0;
    rx_if.frame_start = 1'b0;
    rx_if.serial_in   = 1'b0;
    rx_if.data_ready  = 1'b0;
    model_reset();

    do_reset();
    do_reset();
    chk("rst_data", 32'(rx_if.data_out), 32'h0);
    chk("rst_valid", 32'(rx_if.data_valid), 32'h0);

    // Single frame, consumer always ready: one-cycle valid pulse.
    send_frame(14'h2A5C, 100, 1'b1);
    chk("t1_data", 32'(rx_if.data_out), 32'h2A5C);
    chk("t1_valid", 32'(rx_if.data_valid), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t1_pulse", 32'(rx_if.data_valid), 32'h0);

    // Back-to-back with a stalled consumer: second word dropped.
    send_frame(14'h3FFF, 100, 1'b0);
    send_frame(14'h0001, 100, 1'b0);
    chk("t2_hold", 32'(rx_if.data_out), 32'h3FFF);
    chk("t2_overrun", 32'(rx_if.overrun), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t2_drain", 32'(rx_if.data_valid), 32'h0);
    chk("t2_sticky", 32'(rx_if.overrun), 32'h1);
    do_reset();

    // Aborted partial frame followed by a restart.
    for (int i = 0; i < 6; i++) step(1'b1, i == 0, 1'($urandom_range(1)), 1'b1);
    chk("t3_partial", 32'(rx_if.data_valid), 32'h0);
    send_frame(14'h1234, 100, 1'b1);
    chk("t3_data", 32'(rx_if.data_out), 32'h1234);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Gappy qualifier with noise on unqualified cycles.
    send_frame(14'h0AAA, 50, 1'b1);
    chk("t4_data", 32'(rx_if.data_out), 32'h0AAA);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Reset mid-frame clears everything, including a pending word.
    send_frame(14'h1555, 100, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b1, i == 0, 1'($urandom_range(1)), 1'b0);
    do_reset();
    chk("t5_rst_data", 32'(rx_if.data_out), 32'h0);
    chk("t5_rst_valid", 32'(rx_if.data_valid), 32'h0);
    chk("t5_rst_busy", 32'(rx_if.busy), 32'h0);
    send_frame(14'h2222, 100, 1'b1);
    chk("t5_data", 32'(rx_if.data_out), 32'h2222);
    step(1'b0, 1'b0, 1'b0, 1'b1);

`ifdef RX_PARITY_EN
    send_frame_par(14'h0003, 1'b1);
    chk("t6_perr_bad", 32'(rx_if.parity_err), 32'h1);
    send_frame_par(14'h0003, 1'b0);
    chk("t6_perr_good", 32'(rx_if.parity_err), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
`endif

    // Full-rate back-to-back frames with an always-ready consumer.
    do_reset();
    for (int f = 0; f < 6; f++) send_frame(N'($urandom), 100, 1'b1);
    chk("b2b_overrun", 32'(rx_if.overrun), 32'h0);

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      step($urandom_range(99) < 70, $urandom_range(99) < 6, 1'($urandom_range(1)),
           $urandom_range(99) < 50);
      if (c == 300) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
